// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the banked data memory.
// Size codes, FSM state and byte-count decoding.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    // Number of bytes moved for a size code (size 3 decodes to 8 and is rejected).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One byte-wide synchronous RAM bank.
// Read-first: dout returns the old byte when read and write hit the same row.
module mem_bank #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [2**AW];

    // Write when enabled; always register the pre-write contents of the row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/banked_data_memory.sv
// Byte-addressed little-endian data memory over NB byte banks.
// Row-crossing accesses take a second cycle on the next (wrapping) row.
module banked_data_memory
    import data_mem_pkg::*;
#(
    parameter  int ADDR_LEN = 16,
    parameter  int NB       = 2,
    localparam int DATA_W   = 8 * NB
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int LG = $clog2(NB);
    localparam int RW = ADDR_LEN - LG;
    localparam logic [4:0] NB5 = 5'(NB);

    state_t              state, state_nxt;
    logic                accept;
    logic [3:0]          req_n;
    logic [LG-1:0]       req_off;
    logic                req_err, req_split;
    logic                lat_write, lat_signed;
    logic [1:0]          lat_size;
    logic [ADDR_LEN-1:0] lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [3:0]          lat_n;
    logic [LG-1:0]       lat_off;
    logic                resp_split;
    logic [7:0]          bank_dout [NB];
    logic [7:0]          hold [NB];
    logic [DATA_W-1:0]   load_data;
    logic                in_split, we_first, we_second;
    logic [LG-1:0]       off_sel;
    logic [3:0]          n_sel;
    logic [DATA_W-1:0]   data_sel;
    logic [RW-1:0]       row_sel;

    assign req_n     = size_bytes(req_size);
    assign req_off   = req_addr[LG-1:0];
    assign req_err   = (req_size == 2'd3) || (5'(req_n) > NB5);
    assign req_split = !req_err && (5'(req_off) + 5'(req_n) > NB5);
    assign accept    = req_valid && req_ready && !rst;
    assign lat_n     = size_bytes(lat_size);
    assign lat_off   = lat_addr[LG-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: a row-crossing request spends one extra cycle in SPLIT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept && req_split) state_nxt = SPLIT;
            SPLIT: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: new requests are blocked while the second half runs.
    always_comb begin
        req_ready = (state == IDLE);
        in_split  = (state == SPLIT);
    end

    // Latch request attributes on accept; they also describe the pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (accept) begin
            lat_write  <= req_write;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    // Response pulse: next cycle for single-row or error, after SPLIT otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_split <= 1'b0;
        end else begin
            resp_valid <= (accept && !req_split) || in_split;
            resp_err   <= accept && req_err;
            resp_split <= in_split;
        end
    end

    // Keep the first-row bytes while the second row is being read.
    always_ff @(posedge clk) begin
        if (in_split) hold <= bank_dout;
    end

    // Steering sources: live request in IDLE, latched request in SPLIT.
    always_comb begin
        off_sel   = in_split ? lat_off : req_off;
        n_sel     = in_split ? lat_n : req_n;
        data_sel  = in_split ? lat_wdata : req_wdata;
        row_sel   = in_split ? lat_addr[ADDR_LEN-1:LG] + RW'(1)
                             : req_addr[ADDR_LEN-1:LG];
        we_first  = accept && req_write && !req_err;
        we_second = in_split && lat_write && !rst;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        localparam logic [LG-1:0] BI = LG'(b);
        logic [LG-1:0] k;
        logic          next_row;
        logic          we;

        assign k        = BI - off_sel;
        assign next_row = BI < off_sel;
        assign we       = (4'(k) < n_sel) &&
                          (in_split ? (we_second && next_row)
                                    : (we_first && !next_row));

        mem_bank #(.AW(RW)) u_bank (
            .clk  (clk),
            .we   (we),
            .addr (row_sel),
            .din  (data_sel[8*k +: 8]),
            .dout (bank_dout[b])
        );
    end

    // Rotate bank bytes back into address order, then sign/zero extend.
    always_comb begin
        logic [LG-1:0] bank;
        logic [4:0]    pos;
        logic [7:0]    byte_v;
        logic          sign;
        load_data = '0;
        sign      = 1'b0;
        bank      = '0;
        pos       = '0;
        byte_v    = '0;
        for (int k = 0; k < NB; k++) begin
            bank   = lat_off + LG'(k);
            pos    = 5'(lat_off) + 5'(k);
            byte_v = (resp_split && pos < NB5) ? hold[bank] : bank_dout[bank];
            if (5'(k) < 5'(lat_n)) load_data[8*k +: 8] = byte_v;
            if (5'(k + 1) == 5'(lat_n)) sign = lat_signed && byte_v[7];
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= 8 * int'(lat_n)) load_data[i] = sign;
        end
    end

    assign resp_rdata = (resp_valid && !resp_err && !lat_write) ? load_data : '0;

endmodule
